// File: rtl/bank_pkg.sv
// Shared types and default parameters for the bank request issuer.
//   state_t   : issuer FSM states (IDLE, CMD, WAIT)
//   op_t      : operation held for the current bank access (write, read, verify read)
//   cnt_width : width needed for a down-counter that must hold max_val
package bank_pkg;

    localparam int BANK_AW     = 6;
    localparam int BANK_DW     = 16;
    localparam int BANK_WR_GAP = 2;
    localparam int BANK_RD_GAP = 3;
    localparam int BANK_RD_LAT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_WR  = 2'd0,
        OP_RD  = 2'd1,
        OP_VFY = 2'd2
    } op_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bank_gap_cnt.sv
// Loadable down-counter with terminal-count flags. Used both for the command
// spacing gap and for locating the sense-amp sample point.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (takes priority over dec)
//   load_val  : value to load
//   dec       : decrement by one, saturating at zero
//   zero      : count is 0
//   last      : count is 1 (next decrement reaches zero)
module bank_gap_cnt
    import bank_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);
    assign last = (cnt == W'(1));

endmodule

// File: rtl/bank_req_issuer.sv
// Host-side initiator for the SRAM/CIM bank controller. Accepts one host
// request at a time, issues a single w_en or r_en strobe, holds address/data
// for the whole bank operation, enforces command spacing and returns read
// data as a one-cycle response pulse.
//
// Optional feature: define BANK_WR_VERIFY_EN to follow every write with an
// internal verify read of the same address; a mismatch pulses wr_err.
// Without it wr_err is constant 0.
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   req_valid/req_ready    : host request handshake
//   req_we/addr/wdata      : request op (1 = write), address, write data
//   rsp_valid/rsp_rdata    : one-cycle read response
//   w_en/r_en              : strobes to the bank controller
//   bank_addr/bank_wdata   : address/data held for the bank operation
//   sa_dout                : sense-amp output
//   wr_err                 : write-verify mismatch pulse
//
// state | meaning
// IDLE  | ready for a host request
// CMD   | strobe cycle (w_en or r_en high)
// WAIT  | command spacing; gap counter running down
module bank_req_issuer
    import bank_pkg::*;
#(
    parameter int AW     = BANK_AW,
    parameter int DW     = BANK_DW,
    parameter int WR_GAP = BANK_WR_GAP,
    parameter int RD_GAP = BANK_RD_GAP,
    parameter int RD_LAT = BANK_RD_LAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          w_en,
    output logic          r_en,
    output logic [AW-1:0] bank_addr,
    output logic [DW-1:0] bank_wdata,
    input  logic [DW-1:0] sa_dout,
    output logic          wr_err
);

    localparam int CW = cnt_width((WR_GAP > RD_GAP) ? WR_GAP : RD_GAP);

    state_t        state;
    op_t           op;
    logic          lat_armed;

    logic          gap_load;
    logic [CW-1:0] gap_load_val;
    logic          gap_last;
    logic          lat_load;
    logic          lat_zero;
    logic          cnt_dec;
    logic          sample;
    logic          op_done;
    logic          unused_gap_zero;
    logic          unused_lat_last;

    // Both counters are loaded in CMD and run down during WAIT.
    assign gap_load     = (state == CMD);
    assign gap_load_val = (op == OP_WR) ? CW'(WR_GAP - 1) : CW'(RD_GAP - 1);
    assign lat_load     = (state == CMD) && (op != OP_WR);
    assign cnt_dec      = (state == WAIT);

    // The sample point always falls inside WAIT since RD_LAT < RD_GAP.
    assign sample = (state == WAIT) && lat_armed && lat_zero;

    // Leave WAIT on the edge where the gap counter reaches zero. A write gap
    // of one cycle has no WAIT cycle at all, so it finishes straight from CMD.
    assign op_done = ((state == CMD) && (op == OP_WR) && (WR_GAP == 1)) ||
                     ((state == WAIT) && gap_last);

    bank_gap_cnt #(.W(CW)) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (gap_load_val),
        .dec      (cnt_dec),
        .zero     (unused_gap_zero),
        .last     (gap_last)
    );

    bank_gap_cnt #(.W(CW)) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (lat_load),
        .load_val (CW'(RD_LAT - 1)),
        .dec      (cnt_dec),
        .zero     (lat_zero),
        .last     (unused_lat_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op         <= OP_WR;
            lat_armed  <= 1'b0;
            req_ready  <= 1'b1;
            w_en       <= 1'b0;
            r_en       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            wr_err     <= 1'b0;
            bank_addr  <= '0;
            bank_wdata <= '0;
        end else begin
            w_en      <= 1'b0;
            r_en      <= 1'b0;
            rsp_valid <= 1'b0;
            wr_err    <= 1'b0;

            if (lat_load) begin
                lat_armed <= 1'b1;
            end else if (sample) begin
                lat_armed <= 1'b0;
            end

            if (sample) begin
                if (op == OP_VFY) begin
`ifdef BANK_WR_VERIFY_EN
                    wr_err <= (sa_dout != bank_wdata);
`endif
                end else begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= sa_dout;
                end
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        bank_addr <= req_addr;
                        if (req_we) begin
                            bank_wdata <= req_wdata;
                        end
                        op        <= req_we ? OP_WR : OP_RD;
                        w_en      <= req_we;
                        r_en      <= !req_we;
                        req_ready <= 1'b0;
                        state     <= CMD;
                    end
                end
                CMD, WAIT: begin
                    if (op_done) begin
`ifdef BANK_WR_VERIFY_EN
                        if (op == OP_WR) begin
                            // Skip IDLE: re-read the same address to verify.
                            op    <= OP_VFY;
                            r_en  <= 1'b1;
                            state <= CMD;
                        end else
`endif
                        begin
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        state <= WAIT;
                    end
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
